// File: rtl/apb_pkg.sv
// Shared types and constants for the APB register slave.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        READY
    } apb_state_e;

    localparam int unsigned MAX_WAIT_STATES = 15;

    localparam logic RESP_OKAY  = 1'b0;
    localparam logic RESP_ERROR = 1'b1;

endpackage

// File: rtl/apb_reg_slave_if.sv
// APB bus bundle between master and register slave.
// The pstrb signal exists only when APB_PSTRB_EN is defined.
interface apb_reg_slave_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [ADDR_WIDTH-1:0]   paddr;
    logic [DATA_WIDTH-1:0]   pwdata;
`ifdef APB_PSTRB_EN
    logic [DATA_WIDTH/8-1:0] pstrb;
`endif
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pready;
    logic                    pslverr;

    modport master (
`ifdef APB_PSTRB_EN
        output pstrb,
`endif
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
`ifdef APB_PSTRB_EN
        input  pstrb,
`endif
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_reg_bank.sv
// Word-indexed register storage with synchronous reset, byte-enable write
// and a combinational read port.
module apb_reg_bank #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IDX_W      = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [IDX_W-1:0]        widx,
    input  logic [DATA_WIDTH/8-1:0] wbe,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [IDX_W-1:0]        ridx,
    output logic [DATA_WIDTH-1:0]   rdata
);
    localparam int unsigned BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Callers only assert we with an in-range index.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < int'(BYTES); b++) begin
                if (wbe[b]) begin
                    mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    generate
        if (DEPTH == (1 << IDX_W)) begin : g_full
            assign rdata = mem[ridx];
        end else begin : g_partial
            assign rdata = (ridx < IDX_W'(DEPTH)) ? mem[ridx] : '0;
        end
    endgenerate

endmodule

// File: rtl/apb_reg_slave.sv
// APB slave with local register bank, programmable wait states and PSLVERR.
// Optional APB4 byte strobes are enabled by defining APB_PSTRB_EN.
module apb_reg_slave
    import apb_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           DEPTH       = 16,
    parameter int unsigned           WAIT_STATES = 0,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
    input  logic          pclk,
    input  logic          preset,
    apb_reg_slave_if.slave bus
);
    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned ALIGN = $clog2(BYTES);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(MAX_WAIT_STATES + 1);

    apb_state_e            state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  err_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] prdata_q;
    logic                  pready_q;
    logic                  pslverr_q;

    logic [BYTES-1:0]      strb;
    logic                  strb_err;
    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-1:0] word;
    logic                  err_c;
    logic [IDX_W-1:0]      idx_c;
    logic [IDX_W-1:0]      rd_idx;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  setup;
    logic                  we;

`ifdef APB_PSTRB_EN
    assign strb     = bus.pstrb;
    assign strb_err = !bus.pwrite && (bus.pstrb != '0);
`else
    assign strb     = '1;
    assign strb_err = 1'b0;
`endif

    assign offset = bus.paddr - BASE_ADDR;
    assign word   = offset >> ALIGN;
    assign idx_c  = IDX_W'(word);
    assign err_c  = (bus.paddr < BASE_ADDR) || (word >= ADDR_WIDTH'(DEPTH)) ||
                    ((offset & ADDR_WIDTH'(BYTES - 1)) != '0) || strb_err;

    assign setup  = bus.psel && !bus.penable;
    // With zero wait states the read happens on the setup edge, before idx_q is loaded.
    assign rd_idx = (state_q == IDLE) ? idx_c : idx_q;
    assign we     = (state_q == READY) && bus.psel && bus.penable && write_q && !err_q;

    apb_reg_bank #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_bank (
        .clk   (pclk),
        .rst   (preset),
        .we    (we),
        .widx  (idx_q),
        .wbe   (strb),
        .wdata (bus.pwdata),
        .ridx  (rd_idx),
        .rdata (rd_data)
    );

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            err_q     <= RESP_OKAY;
            write_q   <= 1'b0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= RESP_OKAY;
        end else begin
            unique case (state_q)
                IDLE: begin
                    pready_q  <= 1'b0;
                    prdata_q  <= '0;
                    pslverr_q <= RESP_OKAY;
                    if (setup) begin
                        idx_q   <= idx_c;
                        err_q   <= err_c;
                        write_q <= bus.pwrite;
                        if (WAIT_STATES == 0) begin
                            state_q   <= READY;
                            pready_q  <= 1'b1;
                            pslverr_q <= err_c ? RESP_ERROR : RESP_OKAY;
                            prdata_q  <= (err_c || bus.pwrite) ? '0 : rd_data;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_W'(WAIT_STATES);
                        end
                    end
                end
                WAIT: begin
                    if (!bus.psel) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_W'(1)) begin
                        state_q   <= READY;
                        cnt_q     <= '0;
                        pready_q  <= 1'b1;
                        pslverr_q <= err_q ? RESP_ERROR : RESP_OKAY;
                        prdata_q  <= (err_q || write_q) ? '0 : rd_data;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                READY: begin
                    if (!bus.psel || bus.penable) begin
                        state_q   <= IDLE;
                        pready_q  <= 1'b0;
                        prdata_q  <= '0;
                        pslverr_q <= RESP_OKAY;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.prdata  = prdata_q;
    assign bus.pready  = pready_q;
    assign bus.pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench: one zero-wait-state and one three-wait-state slave on a shared,
// per-target gated APB bus.
module tb_apb_reg_slave;
    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam int          DEPTH = 16;

    logic        pclk = 1'b0;
    logic        preset = 1'b1;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0, tgt = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0;
    logic [3:0]  pstrb = '0;
    int          tests = 0, fails = 0;
    logic [31:0] exp0 [DEPTH];
    logic [31:0] exp3 [DEPTH];

    always #5 pclk = ~pclk;

    apb_reg_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
    apb_reg_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus3 ();

    assign bus0.psel    = psel & ~tgt;
    assign bus0.penable = penable;
    assign bus0.pwrite  = pwrite;
    assign bus0.paddr   = paddr;
    assign bus0.pwdata  = pwdata;
    assign bus3.psel    = psel & tgt;
    assign bus3.penable = penable;
    assign bus3.pwrite  = pwrite;
    assign bus3.paddr   = paddr;
    assign bus3.pwdata  = pwdata;
`ifdef APB_PSTRB_EN
    assign bus0.pstrb   = pstrb;
    assign bus3.pstrb   = pstrb;
`endif

    apb_reg_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH), .WAIT_STATES(0),
                    .BASE_ADDR(BASE)) dut0 (.pclk(pclk), .preset(preset), .bus(bus0));
    apb_reg_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH), .WAIT_STATES(3),
                    .BASE_ADDR(BASE)) dut3 (.pclk(pclk), .preset(preset), .bus(bus3));

    logic        cur_pready, cur_pslverr;
    logic [31:0] cur_prdata;
    assign cur_pready  = tgt ? bus3.pready  : bus0.pready;
    assign cur_pslverr = tgt ? bus3.pslverr : bus0.pslverr;
    assign cur_prdata  = tgt ? bus3.prdata  : bus0.prdata;

    function automatic logic [31:0] reg_addr(input int idx);
        return BASE + 32'(idx * 4);
    endfunction

    // Setup in the next cycle, then access until pready; completion is the following edge.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [31:0] rdata,
                            output logic err, output int waits);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
        @(negedge pclk);
        penable = 1'b1;
        waits = 0;
        while (!cur_pready && waits < 40) begin
            @(negedge pclk);
            waits++;
        end
        if (!cur_pready) begin
            tests++; fails++;
            $display("FAIL timeout addr=%h: pready never rose", addr);
        end
        rdata = cur_prdata;
        err   = cur_pslverr;
    endtask

    task automatic apb_idle();
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        preset = 1'b1;
        repeat (3) @(negedge pclk);
        tests++;
        if ({bus0.pready, bus0.pslverr, bus0.prdata} !== 34'd0) begin
            fails++;
            $display("FAIL reset_dut0: got rdy=%b err=%b data=%h want 0/0/0",
                     bus0.pready, bus0.pslverr, bus0.prdata);
        end
        tests++;
        if ({bus3.pready, bus3.pslverr, bus3.prdata} !== 34'd0) begin
            fails++;
            $display("FAIL reset_dut3: got rdy=%b err=%b data=%h want 0/0/0",
                     bus3.pready, bus3.pslverr, bus3.prdata);
        end
        preset = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            exp0[i] = '0;
            exp3[i] = '0;
        end
    endtask

    task automatic test_write_read();
        logic [31:0] d; logic e; int w;
        tgt = 1'b0;
        apb_xfer(1'b1, BASE + 32'h8, 32'hDEAD_BEEF, 4'hF, d, e, w);
        exp0[2] = 32'hDEAD_BEEF;
        tests++;
        if (w !== 0 || e !== 1'b0) begin
            fails++; $display("FAIL wr0: got waits=%0d err=%b want 0/0", w, e);
        end
        apb_xfer(1'b0, BASE + 32'h8, '0, 4'h0, d, e, w);
        tests++;
        if (w !== 0 || e !== 1'b0 || d !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL rd0: got waits=%0d err=%b data=%h want 0/0/deadbeef", w, e, d);
        end
        apb_idle();
        tests++;
        if (bus0.pready !== 1'b0 || bus0.prdata !== 32'h0 || bus0.pslverr !== 1'b0) begin
            fails++;
            $display("FAIL rd0_clear: got rdy=%b data=%h err=%b want 0/0/0",
                     bus0.pready, bus0.prdata, bus0.pslverr);
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] d; logic e; int w;
        tgt = 1'b1;
        apb_xfer(1'b1, reg_addr(1), 32'hA5A5_0001, 4'hF, d, e, w);
        exp3[1] = 32'hA5A5_0001;
        tests++;
        if (w !== 3 || e !== 1'b0) begin
            fails++; $display("FAIL wr3: got waits=%0d err=%b want 3/0", w, e);
        end
        apb_xfer(1'b0, reg_addr(1), '0, 4'h0, d, e, w);
        tests++;
        if (w !== 3 || e !== 1'b0 || d !== 32'hA5A5_0001) begin
            fails++; $display("FAIL rd3: got waits=%0d err=%b data=%h want 3/0/a5a50001", w, e, d);
        end
        apb_idle();
    endtask

    task automatic test_errors();
        logic [31:0] d; logic e; int w;
        logic [31:0] bad [3];
        bad[0] = reg_addr(DEPTH);
        bad[1] = BASE + 32'h2;
        bad[2] = BASE - 32'h4;
        tgt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            apb_xfer(1'b1, bad[i], 32'hFFFF_FFFF, 4'hF, d, e, w);
            tests++;
            if (e !== 1'b1 || w !== 0) begin
                fails++; $display("FAIL wr_err%0d: got err=%b waits=%0d want 1/0", i, e, w);
            end
        end
        apb_xfer(1'b0, bad[0], '0, 4'h0, d, e, w);
        tests++;
        if (e !== 1'b1 || d !== 32'h0) begin
            fails++; $display("FAIL rd_err: got err=%b data=%h want 1/0", e, d);
        end
        for (int i = 0; i < DEPTH; i++) begin
            apb_xfer(1'b0, reg_addr(i), '0, 4'h0, d, e, w);
            tests++;
            if (d !== exp0[i] || e !== 1'b0) begin
                fails++; $display("FAIL readback%0d: got %h err=%b want %h/0", i, d, e, exp0[i]);
            end
        end
        apb_idle();
    endtask

    task automatic test_reset_midwait();
        logic [31:0] d; logic e; int w;
        tgt = 1'b1;
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = reg_addr(5);
        pwdata = 32'h1234_5678; pstrb = 4'hF;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        preset = 1'b1;
        @(negedge pclk);
        tests++;
        if (bus3.pready !== 1'b0 || bus3.pslverr !== 1'b0 || bus3.prdata !== 32'h0) begin
            fails++;
            $display("FAIL rst_wait: got rdy=%b err=%b data=%h want 0/0/0",
                     bus3.pready, bus3.pslverr, bus3.prdata);
        end
        preset = 1'b0; psel = 1'b0; penable = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            exp0[i] = '0;
            exp3[i] = '0;
        end
        apb_xfer(1'b0, reg_addr(5), '0, 4'h0, d, e, w);
        tests++;
        if (d !== 32'h0 || e !== 1'b0 || w !== 3) begin
            fails++; $display("FAIL rst_target: got %h err=%b waits=%0d want 0/0/3", d, e, w);
        end
        apb_xfer(1'b0, reg_addr(1), '0, 4'h0, d, e, w);
        tests++;
        if (d !== 32'h0) begin
            fails++; $display("FAIL rst_clears: got %h want 0", d);
        end
        apb_idle();
    endtask

`ifdef APB_PSTRB_EN
    task automatic test_strobe();
        logic [31:0] d; logic e; int w;
        tgt = 1'b0;
        apb_xfer(1'b1, reg_addr(3), 32'hFFFF_FFFF, 4'b0101, d, e, w);
        exp0[3] = 32'h00FF_00FF;
        apb_xfer(1'b1, reg_addr(3), 32'h1234_5678, 4'b0000, d, e, w);
        tests++;
        if (e !== 1'b0) begin
            fails++; $display("FAIL strb_zero_err: got %b want 0", e);
        end
        apb_xfer(1'b0, reg_addr(3), '0, 4'h0, d, e, w);
        tests++;
        if (d !== exp0[3] || e !== 1'b0) begin
            fails++; $display("FAIL strb_data: got %h err=%b want %h/0", d, e, exp0[3]);
        end
        apb_xfer(1'b0, reg_addr(3), '0, 4'h2, d, e, w);
        tests++;
        if (d !== 32'h0 || e !== 1'b1) begin
            fails++; $display("FAIL strb_rd_err: got %h err=%b want 0/1", d, e);
        end
        apb_idle();
    endtask
`endif

    task automatic test_back_to_back();
        logic [31:0] d; logic e; int w;
        tgt = 1'b1;
        apb_xfer(1'b1, reg_addr(7), 32'hCAFE_F00D, 4'hF, d, e, w);
        exp3[7] = 32'hCAFE_F00D;
        apb_xfer(1'b0, reg_addr(7), '0, 4'h0, d, e, w);
        tests++;
        if (d !== exp3[7] || e !== 1'b0 || w !== 3) begin
            fails++; $display("FAIL b2b: got %h err=%b waits=%0d want cafef00d/0/3", d, e, w);
        end
        // Drop psel in the middle of the wait phase.
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = reg_addr(8);
        pwdata = 32'h1111_2222; pstrb = 4'hF;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
        repeat (5) @(negedge pclk);
        tests++;
        if (bus3.pready !== 1'b0) begin
            fails++; $display("FAIL abort_rdy: got %b want 0", bus3.pready);
        end
        apb_xfer(1'b0, reg_addr(8), '0, 4'h0, d, e, w);
        tests++;
        if (d !== 32'h0 || e !== 1'b0 || w !== 3) begin
            fails++; $display("FAIL abort_nowrite: got %h err=%b waits=%0d want 0/0/3", d, e, w);
        end
        apb_idle();
        // Access phase without a setup phase gets no response.
        tgt = 1'b0;
        @(negedge pclk);
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = reg_addr(4); pwdata = 32'h5555_AAAA;
        repeat (3) @(negedge pclk);
        tests++;
        if (bus0.pready !== 1'b0) begin
            fails++; $display("FAIL penable_only: got rdy=%b want 0", bus0.pready);
        end
        psel = 1'b0; penable = 1'b0;
        apb_xfer(1'b0, reg_addr(4), '0, 4'h0, d, e, w);
        tests++;
        if (d !== 32'h0 || w !== 0) begin
            fails++; $display("FAIL penable_only_data: got %h waits=%0d want 0/0", d, w);
        end
        apb_idle();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_wait_states();
        test_errors();
        test_reset_midwait();
`ifdef APB_PSTRB_EN
        test_strobe();
`endif
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
